// File: rtl/chu_vga_thermo_core.sv
// Thermometer overlay for a VGA pixel stream: a 16x130 bordered gauge whose
// interior fills from the bottom up to a level that ramps one step per frame
// toward a programmed target (or jumps straight to it in instant mode).
module chu_vga_thermo_core #(
    parameter int             CD        = 12,
    parameter logic [CD-1:0]  KEY_COLOR = {CD{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam logic [CD-1:0] FILL_RST   = CD'(12'h0F0);
    localparam logic [CD-1:0] BORDER_RST = CD'(12'hFFF);

    logic [10:0]   x0_q, x0_d;
    logic [10:0]   y0_q, y0_d;
    logic [6:0]    target_q, target_d;
    logic [6:0]    level_q, level_d;
    logic          enable_q, enable_d;
    logic          instant_q, instant_d;
    logic [CD-1:0] fill_q, fill_d;
    logic [CD-1:0] border_q, border_d;
    logic          origin_q, origin_d;
    logic [CD-1:0] so_rgb_q, pix_d;

    logic          wr_s;
    logic          frame_start_s;
    logic [6:0]    target_sat_s;
    logic [11:0]   px_s, py_s, bx0_s, bx1_s, by0_s, by1_s, fill_top_s;
    logic          in_rect_s, on_ring_s;

    // Register file writes, frame-start detection and level ramp/instant load
    always_comb begin
        wr_s          = cs && write;
        origin_d      = (x == 11'd0) && (y == 11'd0);
        frame_start_s = origin_d && !origin_q;
        if (wr_data[7:0] > 8'd127) begin
            target_sat_s = 7'd127;
        end else begin
            target_sat_s = wr_data[6:0];
        end

        x0_d      = x0_q;
        y0_d      = y0_q;
        target_d  = target_q;
        fill_d    = fill_q;
        border_d  = border_q;
        enable_d  = enable_q;
        instant_d = instant_q;
        if (wr_s) begin
            case (addr[1:0])
                2'd0: begin
                    x0_d = wr_data[10:0];
                    y0_d = wr_data[26:16];
                end
                2'd1: target_d = target_sat_s;
                2'd2: begin
                    fill_d   = wr_data[CD-1:0];
                    border_d = wr_data[16+CD-1:16];
                end
                2'd3: begin
                    enable_d  = wr_data[0];
                    instant_d = wr_data[1];
                end
                default: x0_d = x0_q;
            endcase
        end else begin
            x0_d = x0_q;
        end

        // The step uses the target that was in force before this edge, so a
        // write landing on a frame-start cycle only matters from the next frame.
        level_d = level_q;
        if (enable_q && instant_q) begin
            level_d = target_q;
        end else if (enable_q && frame_start_s) begin
            if (level_q < target_q) begin
                level_d = level_q + 7'd1;
            end else if (level_q > target_q) begin
                level_d = level_q - 7'd1;
            end else begin
                level_d = level_q;
            end
        end else begin
            level_d = level_q;
        end
    end

    // Pixel classification with 12-bit compares so the far edges never wrap
    always_comb begin
        px_s       = {1'b0, x};
        py_s       = {1'b0, y};
        bx0_s      = {1'b0, x0_q};
        bx1_s      = {1'b0, x0_q} + 12'd15;
        by0_s      = {1'b0, y0_q};
        by1_s      = {1'b0, y0_q} + 12'd129;
        fill_top_s = by1_s - {5'd0, level_q};
        in_rect_s  = (px_s >= bx0_s) && (px_s <= bx1_s) &&
                     (py_s >= by0_s) && (py_s <= by1_s);
        on_ring_s  = (px_s == bx0_s) || (px_s == bx1_s) ||
                     (py_s == by0_s) || (py_s == by1_s);
        pix_d      = si_rgb;
        if (!enable_q || !in_rect_s) begin
            pix_d = si_rgb;
        end else if (on_ring_s) begin
            pix_d = border_q;
        end else if ((py_s >= fill_top_s) && (fill_q != KEY_COLOR)) begin
            pix_d = fill_q;
        end else begin
            pix_d = si_rgb;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            x0_q      <= 11'd0;
            y0_q      <= 11'd0;
            target_q  <= 7'd0;
            level_q   <= 7'd0;
            enable_q  <= 1'b0;
            instant_q <= 1'b0;
            fill_q    <= FILL_RST;
            border_q  <= BORDER_RST;
            origin_q  <= 1'b0;
            so_rgb_q  <= {CD{1'b0}};
        end else begin
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            target_q  <= target_d;
            level_q   <= level_d;
            enable_q  <= enable_d;
            instant_q <= instant_d;
            fill_q    <= fill_d;
            border_q  <= border_d;
            origin_q  <= origin_d;
            so_rgb_q  <= pix_d;
        end
    end

    assign so_rgb = so_rgb_q;

endmodule

// File: tb/tb_chu_vga_thermo_core.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared cycle by cycle against an integer reference model of the gauge.
module tb_chu_vga_thermo_core;

    localparam int CD  = 12;
    localparam int KEY = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   x, y;
    logic          cs, write;
    logic [13:0]   addr;
    logic [31:0]   wr_data;
    logic [CD-1:0] si_rgb;
    logic [CD-1:0] so_rgb;

    int tests_run    = 0;
    int tests_failed = 0;
    int obs;

    // reference model state
    int m_x0, m_y0, m_tgt, m_lvl, m_en, m_inst, m_fill, m_bord, m_prev;

    always #5 clk = ~clk;

    chu_vga_thermo_core #(.CD(CD), .KEY_COLOR(12'h000)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
        .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_pix(input int px, input int py, input int si);
        int bottom;
        bottom = m_y0 + 129;
        if (m_en == 0) return si;
        if (px < m_x0 || px > m_x0 + 15 || py < m_y0 || py > bottom) return si;
        if (px == m_x0 || px == m_x0 + 15 || py == m_y0 || py == bottom) return m_bord;
        if (py >= bottom - m_lvl) return (m_fill == KEY) ? si : m_fill;
        return si;
    endfunction

    task automatic model_edge(input int px, input int py, input bit wr,
                              input int a, input int d, input bit rst_n);
        bit org, fs;
        if (!rst_n) begin
            m_x0 = 0; m_y0 = 0; m_tgt = 0; m_lvl = 0; m_en = 0; m_inst = 0;
            m_fill = 'h0F0; m_bord = 'hFFF; m_prev = 0;
            return;
        end
        org    = (px == 0) && (py == 0);
        fs     = org && !m_prev;
        m_prev = org;
        if (m_en != 0 && m_inst != 0) m_lvl = m_tgt;
        else if (m_en != 0 && fs) begin
            if (m_lvl < m_tgt) m_lvl++;
            else if (m_lvl > m_tgt) m_lvl--;
        end
        if (wr) begin
            case (a & 3)
                0: begin m_x0 = d & 'h7FF; m_y0 = (d >> 16) & 'h7FF; end
                1: m_tgt = ((d & 255) > 127) ? 127 : (d & 255);
                2: begin m_fill = d & 'hFFF; m_bord = (d >> 16) & 'hFFF; end
                default: begin m_en = d & 1; m_inst = (d >> 1) & 1; end
            endcase
        end
    endtask

    // one clock: drive inputs, step model at the edge, compare 1 ns later
    task automatic cyc(input int px, input int py, input int si, input bit c,
                       input bit w, input int a, input int d, input bit rst_n,
                       input string tag);
        int exp;
        x = 11'(px); y = 11'(py); si_rgb = CD'(si);
        cs = c; write = w; addr = 14'(a); wr_data = 32'(d); reset = rst_n;
        exp = rst_n ? model_pix(px, py, si) : 0;
        @(posedge clk);
        model_edge(px, py, c && w, a, d, rst_n);
        #1;
        obs = int'(so_rgb);
        check_eq(tag, obs, exp);
    endtask

    task automatic wr_reg(input int a, input int d);
        cyc(1, 1, 'h008, 1'b1, 1'b1, a, d, 1'b1, "wr");
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cyc(5, 5, 'h123, 1'b0, 1'b0, 0, 0, 1'b0, "rst");
    endtask

    task automatic frame();
        cyc(0, 0, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "origin");
        cyc(0, 0, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "origin_hold");
        cyc(1, 0, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "post_origin");
    endtask

    // count fill pixels down an interior column; equals the level
    task automatic scan_level(input int exp, input string tag);
        int cnt;
        int cx, cy0, fill_now;
        cnt = 0; cx = m_x0 + 5; cy0 = m_y0; fill_now = m_fill;
        for (int r = 1; r <= 128; r++) begin
            cyc(cx, cy0 + r, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "scan");
            if (obs == fill_now) cnt++;
        end
        check_eq(tag, cnt, exp);
    endtask

    initial begin
        int lv, px, py, a, d;
        x = 11'd0; y = 11'd0; cs = 1'b0; write = 1'b0; addr = 14'd0;
        wr_data = 32'd0; si_rgb = '0; reset = 1'b0;

        // reset state and basic ramp 1..40
        do_reset();
        wr_reg(0, (50 << 16) | 100);
        wr_reg(1, 40);
        wr_reg(3, 1);
        scan_level(0, "level_start");
        for (int i = 1; i <= 44; i++) begin
            frame();
            scan_level((i < 40) ? i : 40, "ramp_up");
        end
        cyc(105, 139, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "row139");
        check_eq("row139_fill", obs, 'h0F0);
        cyc(100, 139, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "row139_border");
        check_eq("left_border", obs, 'hFFF);

        // reset mid-ramp, ramp to 20 toward 40, then reverse to 10
        do_reset();
        scan_level(0, "after_reset");
        wr_reg(0, (50 << 16) | 100);
        wr_reg(1, 40);
        wr_reg(3, 1);
        for (int i = 0; i < 20; i++) frame();
        scan_level(20, "at20");
        wr_reg(1, 10);
        lv = 20;
        for (int i = 0; i < 12; i++) begin
            frame();
            lv = (lv > 10) ? lv - 1 : 10;
            scan_level(lv, "ramp_down");
        end
        // write on the frame-start cycle uses the old target
        cyc(0, 0, 'h008, 1'b1, 1'b1, 1, 20, 1'b1, "fs_write");
        cyc(2, 2, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "fs_after");
        scan_level(10, "old_target");
        frame();
        scan_level(11, "new_target");

        // saturating target with instant load
        wr_reg(1, 200);
        wr_reg(3, 3);
        cyc(2, 2, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "idle");
        frame();
        scan_level(127, "instant_sat");

        // disabled: everything passes
        wr_reg(3, 0);
        for (int i = 0; i < 200; i++) begin
            px = (i % 2) ? $urandom_range(100, 115) : $urandom_range(0, 639);
            py = (i % 2) ? $urandom_range(50, 179) : $urandom_range(1, 479);
            cyc(px, py, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "disabled");
        end
        check_eq("disabled_pass", obs, 'h008);

        // right screen edge, no wrap
        wr_reg(0, (50 << 16) | 630);
        wr_reg(3, 3);
        for (int r = 45; r <= 185; r += 4) begin
            for (int c = 625; c <= 645; c++) begin
                px = (c > 639) ? c - 640 : c;
                cyc(px, r, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "edge");
            end
        end
        cyc(630, 100, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "edge_b");
        check_eq("edge_border", obs, 'hFFF);
        cyc(639, 100, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "edge_f");
        check_eq("edge_fill", obs, 'h0F0);
        cyc(3, 100, 'h008, 1'b0, 1'b0, 0, 0, 1'b1, "edge_w");
        check_eq("no_wrap", obs, 'h008);

        // transparent fill
        wr_reg(0, (50 << 16) | 100);
        wr_reg(2, ('hFFF << 16) | KEY);
        cyc(105, 150, 'h00A, 1'b0, 1'b0, 0, 0, 1'b1, "key_i");
        check_eq("key_interior", obs, 'h00A);
        cyc(115, 150, 'h00A, 1'b0, 1'b0, 0, 0, 1'b1, "key_b");
        check_eq("key_border", obs, 'hFFF);

        // randomized traffic
        wr_reg(2, ('hFFF << 16) | 'h0F0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                px = 0; py = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                px = m_x0 + $urandom_range(0, 15);
                py = m_y0 + $urandom_range(0, 129);
                if (px > 2047) px = 2047;
                if (py > 2047) py = 2047;
            end else begin
                px = $urandom_range(0, 639); py = $urandom_range(0, 479);
            end
            a = $urandom_range(0, 16383);
            case (a & 3)
                0: d = ($urandom_range(0, 479) << 16) | $urandom_range(0, 639);
                1: d = $urandom_range(0, 255);
                2: d = $urandom;
                default: d = $urandom_range(0, 3) | ($urandom_range(0, 3) == 0 ? 0 : 1);
            endcase
            cyc(px, py, $urandom_range(0, 4095), $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 499) != 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
